player_damage_controller: RTL and testbench
===========================================

# player_damage_controller

Converts the player/attack collision flag from the collider pipeline into health-bar damage for the game UI runtime. Each new contact subtracts `healt_bar_sensitivity` pixels from the bar, then opens an invincibility window of a fixed number of centi-second ticks. Damage saturates at the full bar width, and death latches. Sits between the collider runtime, which produces `is_trigger_player`, and the game UI runtime, which consumes `healt_bar_w_minus`.

## Interface
Parameters:
- `IFRAME_TICKS`, default 20: invincibility length in `tick_centi` strobes (200 ms). Legal range 1..255.
- `W`, default 10: health-bar width bits.

Ports:
- `clk`, in, 1: system clock.
- `clk_reset`, in, 1: asynchronous, active-low reset.
- `tick_centi`, in, 1: one-cycle strobe every 10 ms.
- `is_trigger_player`, in, 1: level; player overlaps a damaging object this cycle.
- `reset_healt_status`, in, 1: one-cycle pulse; restore full health.
- `healt_bar_w`, in, W: full bar width in pixels. Stable while the block is not in reset.
- `healt_bar_sensitivity`, in, 7: damage per hit, in pixels.
- `healt_bar_w_minus`, out, W: accumulated damage, 0..`healt_bar_w`.
- `hit_pulse`, out, 1: one-cycle strobe per registered hit.
- `invincible`, out, 1: high during HIT and COOLDOWN. Drives player blink.
- `player_dead`, out, 1: latched when damage reaches the full bar.

## Operation
- State machine with four states: IDLE, HIT, COOLDOWN, DEAD.
- IDLE:
  - If `is_trigger_player` = 1, compute `sum = {1'b0, healt_bar_w_minus} + healt_bar_sensitivity` (W+1 bits).
  - If `sum >= healt_bar_w`: set `healt_bar_w_minus = healt_bar_w`, go to DEAD, set `player_dead` = 1.
  - Otherwise: set `healt_bar_w_minus = sum` and go to HIT.
  - Either way, `hit_pulse` = 1 for that one cycle.
- HIT:
  - Lasts exactly one cycle.
  - Load `iframe_cnt` = `IFRAME_TICKS`, then go to COOLDOWN.
  - `tick_centi` is ignored here.
- COOLDOWN:
  - On each `tick_centi`, decrement `iframe_cnt`.
  - When a tick arrives with `iframe_cnt` = 1, go to IDLE.
  - `is_trigger_player` is ignored.
- DEAD:
  - Holds all outputs.
  - Exits only via `reset_healt_status`.
- `healt_bar_sensitivity` = 0: a hit is still registered (`hit_pulse`, invincibility window), with no damage.
- Continuous contact: after COOLDOWN returns to IDLE, a still-high trigger registers a new hit on the next cycle. Rate is one hit per `IFRAME_TICKS` ticks plus 2 cycles.
- `reset_healt_status`:
  - Synchronous; has priority over everything else in its cycle.
  - Sets `healt_bar_w_minus` = 0, `player_dead` = 0, `iframe_cnt` = 0, state IDLE.
  - If it coincides with a trigger, no hit is registered that cycle.
- `clk_reset` low (any time, including mid-COOLDOWN):
  - State IDLE.
  - Outputs `healt_bar_w_minus` = 0, `hit_pulse` = 0, `invincible` = 0, `player_dead` = 0.
  - `iframe_cnt` = 0.

## Timing
- All outputs are registered.
- Trigger sampled high at edge N → `hit_pulse` and the new `healt_bar_w_minus` are visible after edge N.
- `invincible` rises after edge N (the same edge that enters HIT), stays high through COOLDOWN, and falls after the edge on which the final tick is consumed.
- Invincibility duration: 1 cycle (HIT) plus the time to `IFRAME_TICKS` ticks, counted from the first tick after HIT.
- `hit_pulse` is never high on two consecutive cycles.
- `player_dead` rises on the same edge as the saturating `hit_pulse`. It stays high until `reset_healt_status` or `clk_reset`.
- `tick_centi` and the trigger in the same IDLE cycle: the hit is taken, and the tick does not count toward cooldown.

## Test plan
1. Reset low mid-COOLDOWN, then release.
   - Required: all outputs 0; state IDLE.
   - Required: next trigger registers a hit immediately.
2. `healt_bar_w` = 200, sensitivity = 15, `IFRAME_TICKS` = 3, trigger held high for 1 cycle.
   - Required: `healt_bar_w_minus` = 15.
   - Required: `hit_pulse` is a 1-cycle pulse.
   - Required: `invincible` high until the 3rd tick after HIT.
3. Trigger held high continuously, same settings.
   - Required: `healt_bar_w_minus` steps 15, 30, 45…
   - Required: consecutive `hit_pulse` events are separated by the 3-tick window plus 2 cycles.
   - Required: no hits during COOLDOWN.
4. `healt_bar_w_minus` = 190, width 200, sensitivity 15, trigger.
   - Required: `healt_bar_w_minus` = 200 (saturated, not 205).
   - Required: `player_dead` = 1.
   - Required: further triggers produce no `hit_pulse`.
5. DEAD, then `reset_healt_status` pulse asserted in the same cycle as a trigger.
   - Required: `healt_bar_w_minus` = 0, `player_dead` = 0, no `hit_pulse`.
   - Required: the following cycle, with trigger still high, a hit is registered with `healt_bar_w_minus` = 15.
6. Sensitivity = 0, trigger.
   - Required: `hit_pulse` = 1 and the `invincible` window runs.
   - Required: `healt_bar_w_minus` unchanged.

Source files
------------

// File: rtl/player_damage_controller.sv
// Health-bar damage controller: turns collider contact into bar damage, then opens an
// invincibility window of IFRAME_TICKS centi-second ticks. Damage saturates and death latches.
module player_damage_controller #(
    parameter int unsigned IFRAME_TICKS = 20,
    parameter int unsigned W            = 10
) (
    input  logic         clk,
    input  logic         clk_reset,
    input  logic         tick_centi,
    input  logic         is_trigger_player,
    input  logic         reset_healt_status,
    input  logic [W-1:0] healt_bar_w,
    input  logic [6:0]   healt_bar_sensitivity,
    output logic [W-1:0] healt_bar_w_minus,
    output logic         hit_pulse,
    output logic         invincible,
    output logic         player_dead
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HIT,
        S_COOLDOWN,
        S_DEAD
    } state_t;

    state_t       r_state;
    logic [7:0]   r_iframe_cnt;
    logic [W-1:0] r_minus;
    logic         r_hit_pulse;
    logic         r_invincible;
    logic         r_dead;

    logic [W:0]   w_sum;
    logic         w_saturate;

    // One extra bit so the add cannot wrap before the saturation compare.
    assign w_sum      = {1'b0, r_minus} + {{(W-6){1'b0}}, healt_bar_sensitivity};
    assign w_saturate = (w_sum >= {1'b0, healt_bar_w});

    always_ff @(posedge clk or negedge clk_reset) begin
        if (!clk_reset) begin
            r_state      <= S_IDLE;
            r_iframe_cnt <= '0;
            r_minus      <= '0;
            r_hit_pulse  <= 1'b0;
            r_invincible <= 1'b0;
            r_dead       <= 1'b0;
        end else if (reset_healt_status) begin
            r_state      <= S_IDLE;
            r_iframe_cnt <= '0;
            r_minus      <= '0;
            r_hit_pulse  <= 1'b0;
            r_invincible <= 1'b0;
            r_dead       <= 1'b0;
        end else begin
            r_hit_pulse <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (is_trigger_player) begin
                        r_hit_pulse <= 1'b1;
                        if (w_saturate) begin
                            r_minus <= healt_bar_w;
                            r_dead  <= 1'b1;
                            r_state <= S_DEAD;
                        end else begin
                            r_minus      <= w_sum[W-1:0];
                            r_invincible <= 1'b1;
                            r_state      <= S_HIT;
                        end
                    end
                end
                S_HIT: begin
                    r_iframe_cnt <= 8'(IFRAME_TICKS);
                    r_state      <= S_COOLDOWN;
                end
                S_COOLDOWN: begin
                    if (tick_centi) begin
                        if (r_iframe_cnt == 8'd1) begin
                            r_iframe_cnt <= '0;
                            r_invincible <= 1'b0;
                            r_state      <= S_IDLE;
                        end else begin
                            r_iframe_cnt <= r_iframe_cnt - 8'd1;
                        end
                    end
                end
                S_DEAD: begin
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign healt_bar_w_minus = r_minus;
    assign hit_pulse         = r_hit_pulse;
    assign invincible        = r_invincible;
    assign player_dead       = r_dead;

endmodule

// File: tb/tb_player_damage_controller.sv
// Self-checking bench for player_damage_controller: directed scenarios plus random traffic,
// every cycle compared against a window-based behavioural model.
module tb_player_damage_controller;

    localparam int unsigned IFR = 3;
    localparam int unsigned WB  = 10;

    logic          clk = 1'b0;
    logic          clk_reset;
    logic          tick_centi;
    logic          is_trigger_player;
    logic          reset_healt_status;
    logic [WB-1:0] healt_bar_w;
    logic [6:0]    healt_bar_sensitivity;
    logic [WB-1:0] healt_bar_w_minus;
    logic          hit_pulse;
    logic          invincible;
    logic          player_dead;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Model: damage total, dead latch, hit strobe, and an invincibility window that
    // spends one cycle arming, then lasts IFR ticks.
    int m_dmg;
    bit m_dead, m_hit, m_inv, m_arming;
    int m_left;
    bit prev_hit;

    player_damage_controller #(.IFRAME_TICKS(IFR), .W(WB)) dut (
        .clk                   (clk),
        .clk_reset             (clk_reset),
        .tick_centi            (tick_centi),
        .is_trigger_player     (is_trigger_player),
        .reset_healt_status    (reset_healt_status),
        .healt_bar_w           (healt_bar_w),
        .healt_bar_sensitivity (healt_bar_sensitivity),
        .healt_bar_w_minus     (healt_bar_w_minus),
        .hit_pulse             (hit_pulse),
        .invincible            (invincible),
        .player_dead           (player_dead)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_clear();
        m_dmg = 0; m_dead = 0; m_hit = 0; m_inv = 0; m_arming = 0; m_left = 0;
    endtask

    task automatic model_step();
        int s;
        if (!clk_reset || reset_healt_status) begin
            model_clear();
        end else if (m_dead) begin
            m_hit = 0;
        end else if (m_inv) begin
            m_hit = 0;
            if (m_arming) begin
                m_arming = 0;
                m_left   = IFR;
            end else if (tick_centi) begin
                m_left--;
                if (m_left == 0) m_inv = 0;
            end
        end else if (is_trigger_player) begin
            m_hit = 1;
            s = m_dmg + int'(healt_bar_sensitivity);
            if (s >= int'(healt_bar_w)) begin
                m_dmg  = int'(healt_bar_w);
                m_dead = 1;
            end else begin
                m_dmg    = s;
                m_inv    = 1;
                m_arming = 1;
            end
        end else begin
            m_hit = 0;
        end
    endtask

    task automatic check();
        chk("damage", int'(healt_bar_w_minus), m_dmg);
        chk("hit_pulse", int'(hit_pulse), int'(m_hit));
        chk("invincible", int'(invincible), int'(m_inv));
        chk("player_dead", int'(player_dead), int'(m_dead));
        chk("hit_not_back_to_back", int'(prev_hit && hit_pulse), 0);
        prev_hit = hit_pulse;
    endtask

    task automatic cycle();
        @(posedge clk);
        cyc++;
        model_step();
        #1;
        check();
    endtask

    task automatic async_reset();
        clk_reset = 1'b0;
        #2;
        model_clear();
        check();
        chk("areset_damage", int'(healt_bar_w_minus), 0);
        chk("areset_inv", int'(invincible), 0);
        cycle();
        clk_reset = 1'b1;
    endtask

    task automatic wait_window_out(input int max_cycles);
        int k;
        is_trigger_player = 1'b0;
        tick_centi        = 1'b1;
        for (k = 0; k < max_cycles && invincible; k++) cycle();
        tick_centi = 1'b0;
        chk("window_closes_in_budget", int'(invincible), 0);
    endtask

    initial begin
        int nticks, k, t_hit[$];
        clk_reset             = 1'b0;
        tick_centi            = 1'b0;
        is_trigger_player     = 1'b0;
        reset_healt_status    = 1'b0;
        healt_bar_w           = WB'(200);
        healt_bar_sensitivity = 7'd15;
        prev_hit              = 1'b0;
        model_clear();
        #3;
        check();
        cycle();
        chk("reset_damage_literal", int'(healt_bar_w_minus), 0);
        #2 clk_reset = 1'b1;
        cycle();

        // Single-cycle hit: 15 damage, pulse one cycle, window runs 3 ticks after HIT.
        is_trigger_player = 1'b1;
        cycle();
        chk("t2_damage15", int'(healt_bar_w_minus), 15);
        chk("t2_hit", int'(hit_pulse), 1);
        chk("t2_inv_rise", int'(invincible), 1);
        is_trigger_player = 1'b0;
        tick_centi        = 1'b1;
        cycle();
        chk("t2_hit_one_cycle", int'(hit_pulse), 0);
        chk("t2_tick_in_hit_ignored", int'(invincible), 1);
        nticks = 0;
        for (k = 0; k < 40 && invincible; k++) begin
            tick_centi = ((k % 3) == 2);
            cycle();
            if (tick_centi) nticks++;
        end
        tick_centi = 1'b0;
        chk("t2_ticks_in_window", nticks, 3);
        chk("t2_inv_fell", int'(invincible), 0);

        // Continuous contact with a tick every cycle: hits every 3 ticks + 2 cycles.
        is_trigger_player = 1'b1;
        tick_centi        = 1'b1;
        for (k = 0; k < 12; k++) begin
            cycle();
            if (hit_pulse) t_hit.push_back(cyc);
            if (hit_pulse && t_hit.size() == 1) chk("t3_damage30", int'(healt_bar_w_minus), 30);
            if (hit_pulse && t_hit.size() == 2) chk("t3_damage45", int'(healt_bar_w_minus), 45);
        end
        chk("t3_hit_count", t_hit.size(), 3);
        if (t_hit.size() >= 3) begin
            chk("t3_spacing_a", t_hit[1] - t_hit[0], IFR + 2);
            chk("t3_spacing_b", t_hit[2] - t_hit[1], IFR + 2);
        end
        wait_window_out(20);

        // Async reset in the middle of the window, then an immediate hit.
        is_trigger_player = 1'b1;
        cycle();
        is_trigger_player = 1'b0;
        cycle();
        cycle();
        chk("t1_in_cooldown", int'(invincible), 1);
        async_reset();
        is_trigger_player = 1'b1;
        cycle();
        chk("t1_hit_after_reset", int'(hit_pulse), 1);
        chk("t1_damage15", int'(healt_bar_w_minus), 15);
        wait_window_out(20);

        // Saturation: 190 + 15 clamps to 200 and latches death.
        reset_healt_status = 1'b1;
        cycle();
        reset_healt_status    = 1'b0;
        healt_bar_sensitivity = 7'd95;
        for (int h = 0; h < 2; h++) begin
            is_trigger_player = 1'b1;
            cycle();
            wait_window_out(20);
        end
        chk("t4_damage190", int'(healt_bar_w_minus), 190);
        healt_bar_sensitivity = 7'd15;
        is_trigger_player     = 1'b1;
        cycle();
        chk("t4_damage_saturated", int'(healt_bar_w_minus), 200);
        chk("t4_dead", int'(player_dead), 1);
        chk("t4_hit", int'(hit_pulse), 1);
        for (k = 0; k < 6; k++) begin
            tick_centi = k[0];
            cycle();
            chk("t4_no_hit_dead", int'(hit_pulse), 0);
        end

        // Restore coinciding with a trigger, then a hit the following cycle.
        reset_healt_status = 1'b1;
        cycle();
        chk("t5_damage0", int'(healt_bar_w_minus), 0);
        chk("t5_alive", int'(player_dead), 0);
        chk("t5_no_hit", int'(hit_pulse), 0);
        reset_healt_status = 1'b0;
        cycle();
        chk("t5_hit", int'(hit_pulse), 1);
        chk("t5_damage15", int'(healt_bar_w_minus), 15);
        wait_window_out(20);

        // Zero sensitivity still registers a hit and a window.
        healt_bar_sensitivity = 7'd0;
        is_trigger_player     = 1'b1;
        cycle();
        chk("t6_hit", int'(hit_pulse), 1);
        chk("t6_inv", int'(invincible), 1);
        chk("t6_damage_unchanged", int'(healt_bar_w_minus), 15);
        is_trigger_player = 1'b0;
        wait_window_out(20);

        // Random traffic.
        healt_bar_sensitivity = 7'd15;
        for (int r = 0; r < 800; r++) begin
            is_trigger_player  = ($urandom_range(0, 2) != 0);
            tick_centi         = ($urandom_range(0, 3) == 0);
            reset_healt_status = ($urandom_range(0, 60) == 0);
            if ($urandom_range(0, 40) == 0) healt_bar_sensitivity = 7'($urandom_range(0, 40));
            if ($urandom_range(0, 150) == 0) async_reset();
            else cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
